// File: rtl/vga_sync_decoder_if.sv
// Pixel-stream bundle between a VGA source and vga_sync_decoder.
// Optional macro VGA_RX_CRC_EN adds the frame_crc result.
interface vga_sync_decoder_if;
  logic        pix_ce;
  logic        hs;
  logic        vs;
  logic [7:0]  rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic [7:0]  rgb_out;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_count;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc;

  modport master (
    output pix_ce, hs, vs, rgb_in,
    input  x, y, pix_valid, rgb_out, frame_start, locked, sync_err, err_count, frame_crc
  );
  modport slave (
    input  pix_ce, hs, vs, rgb_in,
    output x, y, pix_valid, rgb_out, frame_start, locked, sync_err, err_count, frame_crc
  );
`else
  modport master (
    output pix_ce, hs, vs, rgb_in,
    input  x, y, pix_valid, rgb_out, frame_start, locked, sync_err, err_count
  );
  modport slave (
    input  pix_ce, hs, vs, rgb_in,
    output x, y, pix_valid, rgb_out, frame_start, locked, sync_err, err_count
  );
`endif
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive front end: recovers x/y from HS/VS, verifies timing, locks and re-emits pixels.
// Optional macro VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT of the emitted pixels.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_BP        = 10,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input logic               clk,
  input logic               rst_n,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic        L_SYNC   = 1'(SYNC_POL);
  localparam logic [10:0] L_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_H_TMO  = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] L_H_BP   = 11'(H_BP);
  localparam logic [10:0] L_H_END  = 11'(H_BP + H_ACTIVE);
  localparam logic [9:0]  L_V_BP   = 10'(V_BP);
  localparam logic [9:0]  L_V_END  = 10'(V_BP + V_ACTIVE);
  localparam logic [9:0]  L_V_TOT  = 10'(V_TOTAL);
  localparam logic [7:0]  L_LOCK   = 8'(LOCK_FRAMES);

  state_t      r_state;
  logic        r_hs_act;
  logic        r_vs_act;
  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [7:0]  r_good;
  logic        r_frame_bad;
  logic        r_line_seen;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_pix_valid;
  logic [7:0]  r_rgb;
  logic        r_frame_start;
  logic        r_locked;
  logic        r_sync_err;
  logic [7:0]  r_err_count;

  state_t      w_state_nxt;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_hs_fall;
  logic        w_vs_fall;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_inc;
  logic [9:0]  w_v_nxt;
  logic        w_frame_ok;
  logic        w_line_bad;
  logic [7:0]  w_good_nxt;
  logic        w_bad_nxt;
  logic        w_seen_nxt;
  logic        w_loss;
  logic        w_in_win;

  assign w_hs_act  = (bus.hs == L_SYNC);
  assign w_vs_act  = (bus.vs == L_SYNC);
  assign w_hs_fall = r_hs_act & ~w_hs_act;
  assign w_vs_fall = r_vs_act & ~w_vs_act;

  // Next values of the saturating position counters; VS fall overrides HS fall.
  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_inc = r_v_cnt;
    w_v_nxt = r_v_cnt;
    if (w_hs_fall) begin
      w_h_nxt = 11'd0;
    end else if (r_h_cnt != 11'h7FF) begin
      w_h_nxt = r_h_cnt + 11'd1;
    end else begin
      w_h_nxt = r_h_cnt;
    end
    if (r_v_cnt != 10'h3FF) begin
      w_v_inc = r_v_cnt + 10'd1;
    end else begin
      w_v_inc = r_v_cnt;
    end
    if (w_vs_fall) begin
      w_v_nxt = 10'd0;
    end else if (w_hs_fall) begin
      w_v_nxt = w_v_inc;
    end else begin
      w_v_nxt = r_v_cnt;
    end
  end

  // A line ending on this very sample still counts toward the frame length.
  assign w_frame_ok = w_hs_fall ? (w_v_inc == L_V_TOT) : (r_v_cnt == L_V_TOT);
  assign w_line_bad = (w_hs_fall & r_line_seen & (r_h_cnt != L_H_LAST)) | (w_h_nxt == L_H_TMO);

  // Lock state machine: next state and acquisition bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_frame_bad;
    w_seen_nxt  = r_line_seen;
    w_loss      = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_good_nxt = 8'd0;
        w_bad_nxt  = 1'b0;
        w_seen_nxt = 1'b0;
        if (w_vs_fall) begin
          w_state_nxt = ST_ACQUIRE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_ACQUIRE: begin
        w_seen_nxt = r_line_seen | w_hs_fall;
        if (w_vs_fall) begin
          w_bad_nxt = 1'b0;
          if (!r_frame_bad && !w_line_bad && w_frame_ok) begin
            w_good_nxt = r_good + 8'd1;
          end else begin
            w_good_nxt = 8'd0;
          end
          if (w_good_nxt == L_LOCK) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_ACQUIRE;
          end
        end else begin
          w_bad_nxt = r_frame_bad | w_line_bad;
        end
      end
      ST_LOCKED: begin
        w_seen_nxt = r_line_seen | w_hs_fall;
        if (w_line_bad || (w_vs_fall && !w_frame_ok)) begin
          w_state_nxt = ST_SEARCH;
          w_loss      = 1'b1;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  assign w_in_win = (w_state_nxt == ST_LOCKED) &&
                    (w_h_nxt >= L_H_BP) && (w_h_nxt < L_H_END) &&
                    (w_v_nxt >= L_V_BP) && (w_v_nxt < L_V_END);

  // Sync history, counters and FSM state advance only on pixel samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_hs_act    <= 1'b0;
      r_vs_act    <= 1'b0;
      r_h_cnt     <= 11'd0;
      r_v_cnt     <= 10'd0;
      r_good      <= 8'd0;
      r_frame_bad <= 1'b0;
      r_line_seen <= 1'b0;
    end else if (bus.pix_ce) begin
      r_state     <= w_state_nxt;
      r_hs_act    <= w_hs_act;
      r_vs_act    <= w_vs_act;
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      r_good      <= w_good_nxt;
      r_frame_bad <= w_bad_nxt;
      r_line_seen <= w_seen_nxt;
    end
  end

  // Registered outputs; the two pulses are squashed on clocks without a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_pix_valid   <= 1'b0;
      r_rgb         <= 8'd0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_err_count   <= 8'd0;
    end else if (bus.pix_ce) begin
      r_pix_valid   <= w_in_win;
      r_x           <= w_in_win ? 10'(w_h_nxt - L_H_BP) : 10'd0;
      r_y           <= w_in_win ? (w_v_nxt - L_V_BP) : 10'd0;
      r_rgb         <= w_in_win ? bus.rgb_in : 8'd0;
      r_frame_start <= w_in_win && (w_h_nxt == L_H_BP) && (w_v_nxt == L_V_BP);
      r_locked      <= (w_state_nxt == ST_LOCKED);
      r_sync_err    <= w_loss;
      if (w_loss && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else begin
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
    end
  end

  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.pix_valid   = r_pix_valid;
  assign bus.rgb_out     = r_rgb;
  assign bus.frame_start = r_frame_start;
  assign bus.locked      = r_locked;
  assign bus.sync_err    = r_sync_err;
  assign bus.err_count   = r_err_count;

`ifdef VGA_RX_CRC_EN
  logic [15:0] r_crc_acc;
  logic [15:0] r_frame_crc;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // CRC of emitted pixels, published at the VS fall that closes a locked frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_acc   <= 16'hFFFF;
      r_frame_crc <= 16'd0;
    end else if (bus.pix_ce) begin
      if (w_vs_fall) begin
        if (r_state == ST_LOCKED) begin
          r_frame_crc <= r_crc_acc;
        end
        r_crc_acc <= 16'hFFFF;
      end else if (w_in_win) begin
        r_crc_acc <= crc16_byte(r_crc_acc, bus.rgb_in);
      end
    end
  end

  assign bus.frame_crc = r_frame_crc;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster (40x20 total, 24x12 active).
module tb_vga_sync_decoder;
  localparam int HA  = 24;
  localparam int HBP = 6;
  localparam int HT  = 40;
  localparam int VA  = 12;
  localparam int VBP = 3;
  localparam int VT  = 20;
  localparam int HSW = 4;
  localparam int VSL = 2;
  localparam int AY0 = VSL + VBP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_BP(HBP), .H_TOTAL(HT), .V_ACTIVE(VA), .V_BP(VBP),
    .V_TOTAL(VT), .SYNC_POL(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int fs_cyc = 0;
  int se_cyc = 0;
  int pv_cnt = 0;
  int px_err = 0;
  int drop_l = -1;
  int drop_p = -1;
  logic lock_pre_vsf;
  logic lock_at_vsf;
  logic [7:0]  last_rgb;
  logic [9:0]  last_x;
  logic [9:0]  last_y;
  logic [15:0] crc_ref = 16'hFFFF;

  always @(negedge clk) begin
    if (bus.frame_start === 1'b1) fs_cyc++;
    if (bus.sync_err === 1'b1) se_cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic send(input logic h, input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.hs = h; bus.vs = v; bus.rgb_in = d; bus.pix_ce = 1'b1;
    @(negedge clk);
    bus.pix_ce = 1'b0;
  endtask

  task automatic drive_line(input int l, input int p0, input int p1, input int len,
                            input int vs_p, input bit stuck, input bit chk);
    logic h, v, act, pre;
    logic [7:0] d;
    for (int p = p0; p < p1; p++) begin
      h   = stuck ? 1'b0 : (p >= len - HSW);
      v   = (l < VSL) || (l == VSL && p < vs_p);
      act = (l >= AY0 && l < AY0 + VA && p >= HBP && p < HBP + HA);
      d   = act ? 8'(p - HBP) : 8'hAA;
      pre = bus.locked;
      send(h, v, d);
      if (l == VSL && p == vs_p) begin lock_pre_vsf = pre; lock_at_vsf = bus.locked; end
      if (pre && !bus.locked && drop_l < 0) begin drop_l = l; drop_p = p; end
      if (act) crc_ref = crc_step(crc_ref, d);
      if (chk) begin
        if (bus.pix_valid === 1'b1) pv_cnt++;
        if (bus.pix_valid !== act || bus.x !== (act ? 10'(p - HBP) : 10'd0) ||
            bus.y !== (act ? 10'(l - AY0) : 10'd0) || bus.rgb_out !== (act ? d : 8'd0)) px_err++;
        if (l == AY0 + VA - 1 && p == HBP + HA - 1) begin
          last_rgb = bus.rgb_out; last_x = bus.x; last_y = bus.y;
        end
      end
    end
  endtask

  task automatic drive_frame(input int vs_p, input int long_l, input int stuck_l, input bit chk);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == long_l) ? HT + 1 : HT;
      drive_line(l, 0, len, len, vs_p, (stuck_l >= 0 && l >= stuck_l && l < stuck_l + 3), chk);
    end
  endtask

  task automatic test_reset;
    bus.pix_ce = 1'b0; bus.hs = 1'b0; bus.vs = 1'b0; bus.rgb_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.locked, bus.pix_valid, bus.frame_start, bus.sync_err, bus.x, bus.y, bus.rgb_out, bus.err_count} !== 40'd0) begin
      errors++; $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%0h locked=%0b err=%0d, expected all 0", bus.x, bus.y, bus.rgb_out, bus.locked, bus.err_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL nom_vsf1_lock: got %0b expected 0", lock_at_vsf); end
    drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL nom_vsf2_lock: got %0b expected 0", lock_at_vsf); end
    fs_cyc = 0; pv_cnt = 0; px_err = 0;
    drive_frame(20, -1, -1, 1'b1);
    checks++; if (lock_pre_vsf !== 1'b0) begin errors++; $display("FAIL nom_pre_vsf3: got %0b expected 0", lock_pre_vsf); end
    checks++; if (lock_at_vsf !== 1'b1) begin errors++; $display("FAIL nom_vsf3_lock: got %0b expected 1", lock_at_vsf); end
    checks++; if (pv_cnt !== HA * VA) begin errors++; $display("FAIL nom_pv_count: got %0d expected %0d", pv_cnt, HA * VA); end
    checks++; if (px_err !== 0) begin errors++; $display("FAIL nom_pixels: got %0d bad samples expected 0", px_err); end
    checks++; if (fs_cyc !== 1) begin errors++; $display("FAIL nom_frame_start: got %0d cycles expected 1", fs_cyc); end
    checks++; if (last_rgb !== 8'h17) begin errors++; $display("FAIL nom_last_rgb: got %0h expected 17", last_rgb); end
    checks++; if (last_x !== 10'd23 || last_y !== 10'd11) begin errors++; $display("FAIL nom_last_xy: got %0d,%0d expected 23,11", last_x, last_y); end
    checks++; if (bus.err_count !== 8'd0 || se_cyc !== 0) begin errors++; $display("FAIL nom_no_err: got cnt=%0d pulses=%0d expected 0,0", bus.err_count, se_cyc); end
  endtask

  task automatic test_line_error;
    se_cyc = 0; drop_l = -1; drop_p = -1;
    drive_frame(20, 8, -1, 1'b0);
    checks++; if (drop_l !== 9 || drop_p !== 0) begin errors++; $display("FAIL lerr_drop_at: got l%0d p%0d expected l9 p0", drop_l, drop_p); end
    checks++; if (se_cyc !== 1) begin errors++; $display("FAIL lerr_sync_err: got %0d cycles expected 1", se_cyc); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL lerr_count: got %0d expected 1", bus.err_count); end
    drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL lerr_f1_lock: got %0b expected 0", lock_at_vsf); end
    drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL lerr_f2_lock: got %0b expected 0", lock_at_vsf); end
    drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b1) begin errors++; $display("FAIL lerr_relock: got %0b expected 1", lock_at_vsf); end
  endtask

  task automatic test_stuck_hs;
    se_cyc = 0; drop_l = -1; drop_p = -1;
    drive_frame(20, -1, 8, 1'b0);
    checks++; if (drop_l !== 9 || drop_p !== 39) begin errors++; $display("FAIL stuck_drop_at: got l%0d p%0d expected l9 p39", drop_l, drop_p); end
    checks++; if (bus.err_count !== 8'd2) begin errors++; $display("FAIL stuck_count: got %0d expected 2", bus.err_count); end
    checks++; if (se_cyc !== 1) begin errors++; $display("FAIL stuck_sync_err: got %0d cycles expected 1", se_cyc); end
    repeat (3) drive_frame(20, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b1) begin errors++; $display("FAIL stuck_relock: got %0b expected 1", lock_at_vsf); end
  endtask

  task automatic test_reset_midframe;
    for (int l = 0; l < 8; l++) drive_line(l, 0, HT, HT, 20, 1'b0, 1'b0);
    drive_line(8, 0, 21, HT, 20, 1'b0, 1'b0);
    checks++; if (bus.locked !== 1'b1 || bus.x !== 10'd14 || bus.y !== 10'd3) begin errors++; $display("FAIL rst_pre_state: got lock=%0b x=%0d y=%0d expected 1,14,3", bus.locked, bus.x, bus.y); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lock: got lock=%0b valid=%0b expected 0,0", bus.locked, bus.pix_valid); end
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin errors++; $display("FAIL rst_mid_xy: got %0d,%0d expected 0,0", bus.x, bus.y); end
    checks++; if (bus.rgb_out !== 8'd0) begin errors++; $display("FAIL rst_mid_rgb: got %0h expected 0", bus.rgb_out); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", bus.err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_line(8, 21, HT, HT, 20, 1'b0, 1'b0);
    for (int l = 9; l < VT; l++) drive_line(l, 0, HT, HT, 20, 1'b0, 1'b0);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_no_early_lock: got %0b expected 0", bus.locked); end
  endtask

  task automatic test_coincident;
    drive_frame(0, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL coin_f1_lock: got %0b expected 0", lock_at_vsf); end
    drive_frame(0, -1, -1, 1'b0);
    checks++; if (lock_at_vsf !== 1'b0) begin errors++; $display("FAIL coin_f2_lock: got %0b expected 0", lock_at_vsf); end
    fs_cyc = 0; pv_cnt = 0; px_err = 0; crc_ref = 16'hFFFF;
    drive_frame(0, -1, -1, 1'b1);
    checks++; if (lock_pre_vsf !== 1'b0 || lock_at_vsf !== 1'b1) begin errors++; $display("FAIL coin_lock_edge: got pre=%0b at=%0b expected 0,1", lock_pre_vsf, lock_at_vsf); end
    checks++; if (pv_cnt !== HA * VA) begin errors++; $display("FAIL coin_pv_count: got %0d expected %0d", pv_cnt, HA * VA); end
    checks++; if (px_err !== 0) begin errors++; $display("FAIL coin_pixels: got %0d bad samples expected 0", px_err); end
    checks++; if (fs_cyc !== 1) begin errors++; $display("FAIL coin_frame_start: got %0d cycles expected 1", fs_cyc); end
    checks++; if (last_rgb !== 8'h17) begin errors++; $display("FAIL coin_last_rgb: got %0h expected 17", last_rgb); end
  endtask

`ifdef VGA_RX_CRC_EN
  task automatic test_crc;
    logic [15:0] crc_exp;
    crc_exp = crc_ref;
    drive_frame(0, -1, -1, 1'b0);
    checks++; if (bus.frame_crc !== crc_exp) begin errors++; $display("FAIL crc_frame1: got %0h expected %0h", bus.frame_crc, crc_exp); end
    drive_frame(0, -1, -1, 1'b0);
    checks++; if (bus.frame_crc !== crc_exp) begin errors++; $display("FAIL crc_frame2: got %0h expected %0h", bus.frame_crc, crc_exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_line_error();
    test_stuck_hs();
    test_reset_midframe();
    test_coincident();
`ifdef VGA_RX_CRC_EN
    test_crc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
